// File: rtl/tcm_banked_dp.sv
// Dual-port banked TCM: per-bank single-port RAMs, same-cycle service for different banks,
// round-robin arbitration on same-bank conflicts. Optional byte parity under `TCM_PARITY_EN.
module tcm_banked_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8192,
  parameter int BANK_DEPTH = 512,
  parameter int INTERLEAVE = 0,
  parameter int ADDR_WIDTH = $clog2(DEPTH * DATA_WIDTH / 8)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    p0_req_i,
  output logic                    p0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,
  output logic                    p0_rerr_o,
  input  logic                    p1_req_i,
  output logic                    p1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,
  output logic                    p1_rerr_o
);

  localparam int NB       = DATA_WIDTH / 8;
  localparam int BANK_NUM = DEPTH / BANK_DEPTH;
  localparam int BA       = $clog2(BANK_NUM);
  localparam int BAW      = (BA > 0) ? BA : 1;
  localparam int OFF      = $clog2(NB);
  localparam int WA       = $clog2(BANK_DEPTH);
  localparam int WAW      = (WA > 0) ? WA : 1;
`ifdef TCM_PARITY_EN
  localparam int MW       = DATA_WIDTH + NB;
`else
  localparam int MW       = DATA_WIDTH;
`endif

  if (DATA_WIDTH % 8 != 0) begin : g_chk_dw
    $error("tcm_banked_dp: DATA_WIDTH must be a multiple of 8");
  end
  if (DEPTH % BANK_DEPTH != 0) begin : g_chk_depth
    $error("tcm_banked_dp: DEPTH must be a multiple of BANK_DEPTH");
  end
  if ((BANK_DEPTH & (BANK_DEPTH - 1)) != 0) begin : g_chk_bdepth
    $error("tcm_banked_dp: BANK_DEPTH must be a power of two");
  end
  if (BANK_NUM < 1 || (BANK_NUM & (BANK_NUM - 1)) != 0) begin : g_chk_bnum
    $error("tcm_banked_dp: DEPTH/BANK_DEPTH must be a power of two");
  end

  // Bit-by-bit extraction keeps the decode legal when there is only one bank.
  function automatic logic [BAW-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
    logic [BAW-1:0] b;
    b = '0;
    for (int i = 0; i < BA; i++)
      b[i] = (INTERLEAVE != 0) ? a[OFF + i] : a[ADDR_WIDTH - BA + i];
    return b;
  endfunction

  function automatic logic [WAW-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
    logic [WAW-1:0] w;
    w = '0;
    for (int i = 0; i < WA; i++)
      w[i] = (INTERLEAVE != 0) ? a[OFF + BA + i] : a[OFF + i];
    return w;
  endfunction

`ifdef TCM_PARITY_EN
  function automatic logic par_err(input logic [MW-1:0] w);
    logic e;
    e = 1'b0;
    for (int i = 0; i < NB; i++)
      e = e | (^{w[DATA_WIDTH + i], w[8*i +: 8]});
    return e;
  endfunction
`endif

  logic [1:0]            req;
  logic [1:0]            we;
  logic [1:0]            gnt;
  logic [ADDR_WIDTH-1:0] addr  [2];
  logic [NB-1:0]         be    [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic [BAW-1:0]        bank  [2];
  logic [WAW-1:0]        word  [2];

  assign req      = {p1_req_i, p0_req_i};
  assign we       = {p1_we_i, p0_we_i};
  assign addr[0]  = p0_addr_i;
  assign addr[1]  = p1_addr_i;
  assign be[0]    = p0_be_i;
  assign be[1]    = p1_be_i;
  assign wdata[0] = p0_wdata_i;
  assign wdata[1] = p1_wdata_i;

  for (genvar p = 0; p < 2; p++) begin : g_dec
    assign bank[p] = bank_of(addr[p]);
    assign word[p] = word_of(addr[p]);
  end

  // prio names the port that wins the next same-bank conflict.
  logic prio;
  logic conflict;

  assign conflict = req[0] & req[1] & (bank[0] == bank[1]);
  assign gnt[0]   = req[0] & (~conflict | ~prio);
  assign gnt[1]   = req[1] & (~conflict | prio);
  assign p0_gnt_o = gnt[0];
  assign p1_gnt_o = gnt[1];

  // The loser of a conflict is ~prio; it becomes the next winner.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         prio <= 1'b0;
    else if (conflict) prio <= ~prio;
  end

  logic [MW-1:0] bank_rdata [BANK_NUM];

  for (genvar k = 0; k < BANK_NUM; k++) begin : g_bank
    logic                  sel0;
    logic                  sel1;
    logic                  en;
    logic                  bwe;
    logic [WAW-1:0]        wa;
    logic [NB-1:0]         bbe;
    logic [DATA_WIDTH-1:0] bwd;
    logic [MW-1:0]         mem [BANK_DEPTH];
    logic [MW-1:0]         rd_q;

    // Arbitration guarantees at most one of sel0/sel1 is set.
    assign sel0 = gnt[0] & (bank[0] == BAW'(k));
    assign sel1 = gnt[1] & (bank[1] == BAW'(k));
    assign en   = sel0 | sel1;
    assign bwe  = sel1 ? we[1]    : we[0];
    assign wa   = sel1 ? word[1]  : word[0];
    assign bbe  = sel1 ? be[1]    : be[0];
    assign bwd  = sel1 ? wdata[1] : wdata[0];

    always_ff @(posedge clk_i) begin
      if (en) begin
        if (bwe) begin
          for (int i = 0; i < NB; i++) begin
            if (bbe[i]) begin
              mem[wa][8*i +: 8] <= bwd[8*i +: 8];
`ifdef TCM_PARITY_EN
              mem[wa][DATA_WIDTH + i] <= ^bwd[8*i +: 8];
`endif
            end
          end
        end else begin
          rd_q <= mem[wa];
        end
      end
    end

    assign bank_rdata[k] = rd_q;
  end

  // Per-port response tracking: which bank answers and whether it was a read.
  logic [1:0]     rvalid_q;
  logic [1:0]     read_q;
  logic [BAW-1:0] idx_q [2];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= '0;
      read_q   <= '0;
      idx_q[0] <= '0;
      idx_q[1] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        rvalid_q[p] <= gnt[p];
        read_q[p]   <= gnt[p] & ~we[p];
        if (gnt[p]) idx_q[p] <= bank[p];
      end
    end
  end

  logic [DATA_WIDTH-1:0] rdata [2];
  logic [1:0]            rerr;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      rerr[p]  = 1'b0;
      if (rvalid_q[p] & read_q[p]) begin
        rdata[p] = bank_rdata[idx_q[p]][DATA_WIDTH-1:0];
`ifdef TCM_PARITY_EN
        rerr[p]  = par_err(bank_rdata[idx_q[p]]);
`endif
      end
    end
  end

  assign p0_rvalid_o = rvalid_q[0];
  assign p1_rvalid_o = rvalid_q[1];
  assign p0_rdata_o  = rdata[0];
  assign p1_rdata_o  = rdata[1];
  assign p0_rerr_o   = rerr[0];
  assign p1_rerr_o   = rerr[1];

endmodule

// File: tb/tb_tcm_banked_dp.sv
// Bench for tcm_banked_dp: instance 0 uses contiguous banks, instance 1 word interleave.
// Table-driven per-cycle vectors plus hand sequences for reset-in-flight and parity.
module tb_tcm_banked_dp;
  localparam int DW = 32;
  localparam int AW = 15;
  localparam int NB = 4;

  logic clk_i = 1'b0;
  logic rst_i;

  logic          p0_req [2], p0_we [2], p0_gnt [2], p0_rvalid [2], p0_rerr [2];
  logic [AW-1:0] p0_addr [2];
  logic [NB-1:0] p0_be [2];
  logic [DW-1:0] p0_wdata [2], p0_rdata [2];
  logic          p1_req [2], p1_we [2], p1_gnt [2], p1_rvalid [2], p1_rerr [2];
  logic [AW-1:0] p1_addr [2];
  logic [NB-1:0] p1_be [2];
  logic [DW-1:0] p1_wdata [2], p1_rdata [2];

  always #5 clk_i = ~clk_i;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    tcm_banked_dp #(.INTERLEAVE(g)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .p0_req_i   (p0_req[g]),
      .p0_gnt_o   (p0_gnt[g]),
      .p0_addr_i  (p0_addr[g]),
      .p0_we_i    (p0_we[g]),
      .p0_be_i    (p0_be[g]),
      .p0_wdata_i (p0_wdata[g]),
      .p0_rvalid_o(p0_rvalid[g]),
      .p0_rdata_o (p0_rdata[g]),
      .p0_rerr_o  (p0_rerr[g]),
      .p1_req_i   (p1_req[g]),
      .p1_gnt_o   (p1_gnt[g]),
      .p1_addr_i  (p1_addr[g]),
      .p1_we_i    (p1_we[g]),
      .p1_be_i    (p1_be[g]),
      .p1_wdata_i (p1_wdata[g]),
      .p1_rvalid_o(p1_rvalid[g]),
      .p1_rdata_o (p1_rdata[g]),
      .p1_rerr_o  (p1_rerr[g])
    );
  end

  typedef struct {
    int            inst;
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [NB-1:0] be0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [NB-1:0] be1;
    logic [DW-1:0] d1;
    logic          g0, g1;
    logic [DW-1:0] q0, q1;
  } vec_t;

  vec_t vt [$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(int inst,
      logic r0, logic w0, logic [AW-1:0] a0, logic [NB-1:0] be0, logic [DW-1:0] d0,
      logic r1, logic w1, logic [AW-1:0] a1, logic [NB-1:0] be1, logic [DW-1:0] d1,
      logic g0, logic g1, logic [DW-1:0] q0, logic [DW-1:0] q1);
    vec_t v;
    v.inst = inst;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.be0 = be0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.be1 = be1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.q0 = q0; v.q1 = q1;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    for (int j = 0; j < 2; j++) begin
      p0_req[j] = 1'b0; p0_we[j] = 1'b0; p0_addr[j] = '0; p0_be[j] = '0; p0_wdata[j] = '0;
      p1_req[j] = 1'b0; p1_we[j] = 1'b0; p1_addr[j] = '0; p1_be[j] = '0; p1_wdata[j] = '0;
    end
  endtask

  task automatic drive(input vec_t v);
    idle_all();
    p0_req[v.inst] = v.r0; p0_we[v.inst] = v.w0; p0_addr[v.inst] = v.a0;
    p0_be[v.inst] = v.be0; p0_wdata[v.inst] = v.d0;
    p1_req[v.inst] = v.r1; p1_we[v.inst] = v.w1; p1_addr[v.inst] = v.a1;
    p1_be[v.inst] = v.be1; p1_wdata[v.inst] = v.d1;
  endtask

  task automatic chk_gnt(input vec_t v, input string tag);
    for (int j = 0; j < 2; j++) begin
      check($sformatf("%s i%0d gnt0", tag, j), p0_gnt[j], (v.inst == j) ? v.g0 : 1'b0);
      check($sformatf("%s i%0d gnt1", tag, j), p1_gnt[j], (v.inst == j) ? v.g1 : 1'b0);
    end
  endtask

  // Responses visible in the cycle after the vector that was granted.
  task automatic chk_resp(input bit have, input vec_t v, input string tag);
    logic e0, e1;
    for (int j = 0; j < 2; j++) begin
      e0 = have && (v.inst == j) && v.g0;
      e1 = have && (v.inst == j) && v.g1;
      check($sformatf("%s i%0d rvalid0", tag, j), p0_rvalid[j], e0);
      check($sformatf("%s i%0d rvalid1", tag, j), p1_rvalid[j], e1);
      check($sformatf("%s i%0d rdata0", tag, j), p0_rdata[j], e0 ? v.q0 : '0);
      check($sformatf("%s i%0d rdata1", tag, j), p1_rdata[j], e1 ? v.q1 : '0);
      check($sformatf("%s i%0d rerr0", tag, j), p0_rerr[j], 1'b0);
      check($sformatf("%s i%0d rerr1", tag, j), p1_rerr[j], 1'b0);
    end
  endtask

  task automatic chk_idle_out(input string tag);
    for (int j = 0; j < 2; j++) begin
      check($sformatf("%s i%0d rvalid0", tag, j), p0_rvalid[j], 1'b0);
      check($sformatf("%s i%0d rvalid1", tag, j), p1_rvalid[j], 1'b0);
      check($sformatf("%s i%0d rdata0", tag, j), p0_rdata[j], '0);
      check($sformatf("%s i%0d rdata1", tag, j), p1_rdata[j], '0);
      check($sformatf("%s i%0d rerr0", tag, j), p0_rerr[j], 1'b0);
      check($sformatf("%s i%0d rerr1", tag, j), p1_rerr[j], 1'b0);
      check($sformatf("%s i%0d gnt0", tag, j), p0_gnt[j], 1'b0);
      check($sformatf("%s i%0d gnt1", tag, j), p1_gnt[j], 1'b0);
    end
  endtask

  initial begin
    vec_t prev;
    // inst 0: bank = addr[14:11]; inst 1: bank = addr[5:2]
    //          inst r0 w0 a0       be0  d0             r1 w1 a1       be1  d1             g0 g1 q0             q1
    vt.push_back(mk(0, 1, 1, 'h0010, 'hF, 'hDEADBEEF,  0, 0, 'h0000, 'h0, 'h0,          1, 0, 'h0,          'h0));
    vt.push_back(mk(0, 1, 0, 'h0010, 'hF, 'h0,         0, 0, 'h0000, 'h0, 'h0,          1, 0, 'hDEADBEEF,   'h0));
    vt.push_back(mk(0, 1, 1, 'h0000, 'hF, 'hA5A50000,  1, 1, 'h0800, 'hF, 'h0B0B0001,   1, 1, 'h0,          'h0));
    vt.push_back(mk(0, 1, 0, 'h0000, 'hF, 'h0,         1, 0, 'h0800, 'hF, 'h0,          1, 1, 'hA5A50000,   'h0B0B0001));
    vt.push_back(mk(0, 1, 0, 'h0000, 'h0, 'h0,         1, 0, 'h0010, 'h0, 'h0,          1, 0, 'hA5A50000,   'hDEADBEEF));
    vt.push_back(mk(0, 1, 0, 'h0000, 'h0, 'h0,         1, 0, 'h0010, 'h0, 'h0,          0, 1, 'hA5A50000,   'hDEADBEEF));
    vt.push_back(mk(0, 1, 0, 'h0000, 'h0, 'h0,         1, 0, 'h0010, 'h0, 'h0,          1, 0, 'hA5A50000,   'hDEADBEEF));
    vt.push_back(mk(0, 1, 0, 'h0000, 'h0, 'h0,         0, 0, 'h0000, 'h0, 'h0,          1, 0, 'hA5A50000,   'h0));
    vt.push_back(mk(0, 1, 0, 'h0000, 'h0, 'h0,         1, 0, 'h0010, 'h0, 'h0,          0, 1, 'hA5A50000,   'hDEADBEEF));
    vt.push_back(mk(0, 0, 0, 'h0000, 'h0, 'h0,         1, 1, 'h0020, 'hF, 'h11223344,   0, 1, 'h0,          'h0));
    vt.push_back(mk(0, 0, 0, 'h0000, 'h0, 'h0,         1, 1, 'h0020, 'h2, 'h0000AA00,   0, 1, 'h0,          'h0));
    vt.push_back(mk(0, 0, 0, 'h0000, 'h0, 'h0,         1, 0, 'h0020, 'h0, 'h0,          0, 1, 'h0,          'h1122AA44));
    vt.push_back(mk(0, 0, 0, 'h0000, 'h0, 'h0,         1, 1, 'h0020, 'h0, 'hFFFFFFFF,   0, 1, 'h0,          'h0));
    vt.push_back(mk(0, 0, 0, 'h0000, 'h0, 'h0,         1, 0, 'h0020, 'h0, 'h0,          0, 1, 'h0,          'h1122AA44));
    vt.push_back(mk(0, 0, 0, 'h0000, 'h0, 'h0,         0, 0, 'h0000, 'h0, 'h0,          0, 0, 'h0,          'h0));
    vt.push_back(mk(0, 1, 1, 'h7FFC, 'hF, 'hCAFEF00D,  1, 0, 'h0800, 'h0, 'h0,          1, 1, 'h0,          'h0B0B0001));
    vt.push_back(mk(0, 1, 0, 'h7FFE, 'h0, 'h0,         0, 0, 'h0000, 'h0, 'h0,          1, 0, 'hCAFEF00D,   'h0));
    vt.push_back(mk(1, 1, 1, 'h0000, 'hF, 'h11110000,  1, 1, 'h0004, 'hF, 'h22220004,   1, 1, 'h0,          'h0));
    vt.push_back(mk(1, 1, 1, 'h0040, 'hF, 'h33330040,  0, 0, 'h0000, 'h0, 'h0,          1, 0, 'h0,          'h0));
    vt.push_back(mk(1, 1, 0, 'h0000, 'h0, 'h0,         1, 0, 'h0040, 'h0, 'h0,          1, 0, 'h11110000,   'h33330040));
    vt.push_back(mk(1, 1, 0, 'h0000, 'h0, 'h0,         1, 0, 'h0040, 'h0, 'h0,          0, 1, 'h11110000,   'h33330040));
    vt.push_back(mk(1, 1, 0, 'h0004, 'h0, 'h0,         1, 0, 'h0000, 'h0, 'h0,          1, 1, 'h22220004,   'h11110000));

    // Clock/reset
    idle_all();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_idle_out("reset");
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_idle_out("post_reset");

    // Table
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk_i);
      chk_resp(i > 0, prev, $sformatf("v%0d", i - 1));
      drive(vt[i]);
      #1;
      chk_gnt(vt[i], $sformatf("v%0d", i));
      prev = vt[i];
    end
    @(negedge clk_i);
    chk_resp(1'b1, prev, $sformatf("v%0d", vt.size() - 1));
    idle_all();

    // Reset while a response is in flight; prio must also return to port 0.
    @(negedge clk_i);
    p0_req[0] = 1'b1; p0_addr[0] = 'h0000;
    p1_req[0] = 1'b1; p1_addr[0] = 'h0010;
    #1;
    check("rst_seq gnt0", p0_gnt[0], 1'b1);
    check("rst_seq gnt1", p1_gnt[0], 1'b0);
    @(posedge clk_i);
    #1;
    check("rst_seq rvalid before reset", p0_rvalid[0], 1'b1);
    idle_all();
    rst_i = 1'b1;
    #1;
    check("rst_seq rvalid dropped", p0_rvalid[0], 1'b0);
    check("rst_seq rdata dropped", p0_rdata[0], '0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check($sformatf("rst_seq no rvalid c%0d", c), p0_rvalid[0], 1'b0);
    end
    p0_req[0] = 1'b1; p0_addr[0] = 'h0000;
    p1_req[0] = 1'b1; p1_addr[0] = 'h0010;
    #1;
    check("rst_seq prio gnt0", p0_gnt[0], 1'b1);
    check("rst_seq prio gnt1", p1_gnt[0], 1'b0);
    @(negedge clk_i);
    idle_all();
    check("rst_seq ram kept rvalid", p0_rvalid[0], 1'b1);
    check("rst_seq ram kept rdata", p0_rdata[0], 'hA5A50000);
    check("rst_seq ram kept p1 rvalid", p1_rvalid[0], 1'b0);

`ifdef TCM_PARITY_EN
    // Corrupt the stored parity of byte 0 in bank 0, word 0.
    @(negedge clk_i);
    g_dut[0].dut.g_bank[0].mem[0][DW] <= ~g_dut[0].dut.g_bank[0].mem[0][DW];
    @(negedge clk_i);
    p0_req[0] = 1'b1; p0_addr[0] = 'h0000;
    @(negedge clk_i);
    idle_all();
    check("parity rvalid", p0_rvalid[0], 1'b1);
    check("parity rerr", p0_rerr[0], 1'b1);
    check("parity rdata", p0_rdata[0], 'hA5A50000);
    p0_req[0] = 1'b1; p0_we[0] = 1'b1; p0_addr[0] = 'h0000; p0_be[0] = 'h1; p0_wdata[0] = 'h0;
    @(negedge clk_i);
    idle_all();
    check("parity wack rerr", p0_rerr[0], 1'b0);
    p0_req[0] = 1'b1; p0_addr[0] = 'h0000;
    @(negedge clk_i);
    idle_all();
    check("parity repaired rerr", p0_rerr[0], 1'b0);
    check("parity repaired rdata", p0_rdata[0], 'hA5A50000);
`endif

    repeat (2) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
